// File: rtl/jumper_ctrl.sv
// jumper_ctrl: frame-paced jump/fall physics for a single sprite, with
// platform landing, horizontal wrap and a registered sprite-ROM lookup.
// Optional feature macro: JUMPER_SPRING_EN adds the per-platform spring
// input; a landing on a spring launches at twice the take-off speed.
module jumper_ctrl #(
    parameter int NUM_PLAT  = 4,
    parameter int SPR_W     = 80,
    parameter int SPR_H     = 80,
    parameter int FRAME_DIV = 1000000,
    parameter int JUMP_V    = 44,
    parameter int GRAVITY   = 4,
    parameter int X_MIN     = 300,
    parameter int X_MAX     = 642,
    parameter int PLAT_W    = 100,
    parameter int PLAT_TOL  = 30,
    parameter int Y_DEAD    = 768,
    parameter int X_RST     = 472,
    parameter int Y_RST     = 687
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             start,
    input  logic signed [8:0]                                delta_x,
    input  logic [NUM_PLAT-1:0][10:0]                        plat_x,
    input  logic [NUM_PLAT-1:0][9:0]                         plat_y,
    input  logic [NUM_PLAT-1:0]                              plat_valid,
`ifdef JUMPER_SPRING_EN
    input  logic [NUM_PLAT-1:0]                              spring,
`endif
    input  logic [10:0]                                      beam_x,
    input  logic [9:0]                                       beam_y,
    output logic [10:0]                                      pos_x,
    output logic [9:0]                                       pos_y,
    output logic signed [9:0]                                vel_y,
    output logic [1:0]                                       state,
    output logic                                             facing_left,
    output logic                                             frame_tick,
    output logic                                             landed,
    output logic [(NUM_PLAT > 1 ? $clog2(NUM_PLAT) : 1)-1:0] landed_idx,
    output logic                                             spr_hit,
    output logic [6:0]                                       spr_ax,
    output logic [6:0]                                       spr_ay
);

    localparam int IDXW = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
    localparam int CNTW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    // All geometry is evaluated in 12-bit signed so a negative y' stays negative.
    localparam logic signed [11:0] X_MIN_S    = 12'(X_MIN);
    localparam logic signed [11:0] X_MAX_S    = 12'(X_MAX);
    localparam logic signed [11:0] SPR_W_S    = 12'(SPR_W);
    localparam logic signed [11:0] SPR_H_S    = 12'(SPR_H);
    localparam logic signed [11:0] HALF_W_S   = 12'(SPR_W / 2);
    localparam logic signed [11:0] PLAT_W_S   = 12'(PLAT_W);
    localparam logic signed [11:0] PLAT_TOL_S = 12'(PLAT_TOL);
    localparam logic signed [11:0] Y_DEAD_S   = 12'(Y_DEAD);
    localparam logic signed [11:0] GRAV_S     = 12'(GRAVITY);
    localparam logic signed [11:0] V_MAX_S    = 12'sd127;

    localparam logic signed [9:0] V_JUMP = 10'(-JUMP_V);
`ifdef JUMPER_SPRING_EN
    localparam int               V_SPR_I  = (2 * JUMP_V > 512) ? -512 : -2 * JUMP_V;
    localparam logic signed [9:0] V_SPRING = 10'(V_SPR_I);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RISE = 2'd1,
        S_FALL = 2'd2,
        S_DEAD = 2'd3
    } state_e;

    state_e              state_q;
    logic [CNTW-1:0]     cnt_q;
    logic [10:0]         pos_x_q;
    logic [9:0]          pos_y_q;
    logic signed [9:0]   vel_q;
    logic                facing_q;
    logic                landed_q;
    logic [IDXW-1:0]     landed_idx_q;
    logic                spr_hit_q;
    logic [6:0]          spr_ax_q;
    logic [6:0]          spr_ay_q;

    logic                tick;
    logic signed [11:0]  x_sum;
    logic [10:0]         x_d;
    logic signed [11:0]  y_d;
    logic signed [11:0]  v_sum;
    logic signed [9:0]   vel_d;
    logic                facing_d;
    logic signed [11:0]  rel_x;
    logic signed [11:0]  rel_y;
    logic                land_found;
    logic [IDXW-1:0]     land_idx;
    logic [9:0]          land_y;
    logic signed [9:0]   land_v;
    logic                dead_hit;
    logic signed [11:0]  bdx;
    logic signed [11:0]  bdy;
    logic                hit_d;
    logic [6:0]          ax_d;
    logic [6:0]          ay_d;

    assign tick = (cnt_q == CNTW'(FRAME_DIV - 1));

    // Frame divider: free-running 0..FRAME_DIV-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Per-frame physics candidates: wrapped x, new y, saturated velocity, facing.
    always_comb begin
        x_sum = $signed({1'b0, pos_x_q}) + {{3{delta_x[8]}}, delta_x};
        if (x_sum < X_MIN_S) begin
            x_d = 11'(X_MAX - 1);
        end else if (x_sum >= X_MAX_S) begin
            x_d = 11'(X_MIN);
        end else begin
            x_d = x_sum[10:0];
        end

        y_d   = $signed({2'b0, pos_y_q}) + {{2{vel_q[9]}}, vel_q};
        v_sum = {{2{vel_q[9]}}, vel_q} + GRAV_S;
        vel_d = (v_sum > V_MAX_S) ? 10'sd127 : v_sum[9:0];

        if (delta_x < 0) begin
            facing_d = 1'b1;
        end else if (delta_x > 0) begin
            facing_d = 1'b0;
        end else begin
            facing_d = facing_q;
        end
    end

    // Landing search: lowest-index platform whose window contains the sprite foot.
    always_comb begin
        rel_x      = '0;
        rel_y      = '0;
        land_found = 1'b0;
        land_idx   = '0;
        land_y     = '0;
        land_v     = V_JUMP;
        for (int unsigned i = 0; i < NUM_PLAT; i++) begin
            rel_y = y_d + SPR_H_S - $signed({2'b0, plat_y[i]});
            rel_x = $signed({1'b0, x_d}) + HALF_W_S - $signed({1'b0, plat_x[i]});
            if (!land_found && plat_valid[i] &&
                rel_y >= 12'sd0 && rel_y <= PLAT_TOL_S &&
                rel_x >= 12'sd0 && rel_x <  PLAT_W_S) begin
                land_found = 1'b1;
                land_idx   = IDXW'(i);
                land_y     = plat_y[i] - 10'(SPR_H);
`ifdef JUMPER_SPRING_EN
                land_v     = spring[i] ? V_SPRING : V_JUMP;
`endif
            end
        end
        dead_hit = (y_d + SPR_H_S) >= Y_DEAD_S;
    end

    // Motion FSM: every state/position/velocity update waits for the frame tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pos_x_q      <= 11'(X_RST);
            pos_y_q      <= 10'(Y_RST);
            vel_q        <= '0;
            facing_q     <= 1'b0;
            landed_q     <= 1'b0;
            landed_idx_q <= '0;
        end else begin
            landed_q     <= 1'b0;
            landed_idx_q <= '0;
            if (tick) begin
                case (state_q)
                    S_IDLE: begin
                        facing_q <= facing_d;
                        if (start) begin
                            state_q <= S_RISE;
                            vel_q   <= V_JUMP;
                        end
                    end
                    S_RISE: begin
                        facing_q <= facing_d;
                        pos_x_q  <= x_d;
                        pos_y_q  <= y_d[9:0];
                        vel_q    <= vel_d;
                        if (vel_d >= 0) begin
                            state_q <= S_FALL;
                        end
                    end
                    S_FALL: begin
                        facing_q <= facing_d;
                        pos_x_q  <= x_d;
                        if (land_found) begin
                            pos_y_q      <= land_y;
                            vel_q        <= land_v;
                            state_q      <= S_RISE;
                            landed_q     <= 1'b1;
                            landed_idx_q <= land_idx;
                        end else if (dead_hit) begin
                            pos_y_q <= 10'(Y_DEAD - SPR_H);
                            vel_q   <= vel_d;
                            state_q <= S_DEAD;
                        end else begin
                            pos_y_q <= y_d[9:0];
                            vel_q   <= vel_d;
                        end
                    end
                    S_DEAD: begin
                        if (start) begin
                            state_q <= S_IDLE;
                            pos_x_q <= 11'(X_RST);
                            pos_y_q <= 10'(Y_RST);
                            vel_q   <= '0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Beam-relative sprite coordinates; one ROM serves both facings by mirroring x.
    always_comb begin
        bdx   = $signed({1'b0, beam_x}) - $signed({1'b0, pos_x_q});
        bdy   = $signed({2'b0, beam_y}) - $signed({2'b0, pos_y_q});
        hit_d = (bdx >= 12'sd0) && (bdx < SPR_W_S) && (bdy >= 12'sd0) && (bdy < SPR_H_S);
        ax_d  = '0;
        ay_d  = '0;
        if (hit_d) begin
            ax_d = facing_q ? 7'(SPR_W_S - 12'sd1 - bdx) : bdx[6:0];
            ay_d = bdy[6:0];
        end
    end

    // Sprite lookup register: sampled every clk, independent of the frame tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            spr_hit_q <= 1'b0;
            spr_ax_q  <= '0;
            spr_ay_q  <= '0;
        end else begin
            spr_hit_q <= hit_d;
            spr_ax_q  <= ax_d;
            spr_ay_q  <= ay_d;
        end
    end

    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign vel_y       = vel_q;
    assign state       = state_q;
    assign facing_left = facing_q;
    assign frame_tick  = tick;
    assign landed      = landed_q;
    assign landed_idx  = landed_idx_q;
    assign spr_hit     = spr_hit_q;
    assign spr_ax      = spr_ax_q;
    assign spr_ay      = spr_ay_q;

endmodule

// File: tb/tb_jumper_ctrl.sv
// Directed bench for jumper_ctrl with a short frame period.
module tb_jumper_ctrl;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic signed [8:0]       delta_x;
    logic [3:0][10:0]        plat_x;
    logic [3:0][9:0]         plat_y;
    logic [3:0]              plat_valid;
`ifdef JUMPER_SPRING_EN
    logic [3:0]              spring;
`endif
    logic [10:0]             beam_x;
    logic [9:0]              beam_y;
    logic [10:0]             pos_x;
    logic [9:0]              pos_y;
    logic signed [9:0]       vel_y;
    logic [1:0]              state;
    logic                    facing_left;
    logic                    frame_tick;
    logic                    landed;
    logic [1:0]              landed_idx;
    logic                    spr_hit;
    logic [6:0]              spr_ax;
    logic [6:0]              spr_ay;

    int n_checks = 0;
    int n_errors = 0;

    jumper_ctrl #(.FRAME_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .delta_x     (delta_x),
        .plat_x      (plat_x),
        .plat_y      (plat_y),
        .plat_valid  (plat_valid),
`ifdef JUMPER_SPRING_EN
        .spring      (spring),
`endif
        .beam_x      (beam_x),
        .beam_y      (beam_y),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .vel_y       (vel_y),
        .state       (state),
        .facing_left (facing_left),
        .frame_tick  (frame_tick),
        .landed      (landed),
        .landed_idx  (landed_idx),
        .spr_hit     (spr_hit),
        .spr_ax      (spr_ax),
        .spr_ay      (spr_ay)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance through the next frame tick edge; returns #1 after that edge.
    task automatic next_tick();
        int n;
        n = 0;
        while (frame_tick !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (n >= 16) check("tick_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic beam_probe(input int bx, input int by);
        beam_x = 11'(bx);
        beam_y = 10'(by);
        @(posedge clk);
        #1;
    endtask

    int dtab  [1:5] = '{-171, -5, -1, 5, 0};
    int xtab  [1:5] = '{301, 641, 640, 300, 300};
    int ftab  [1:5] = '{1, 1, 1, 0, 0};
    int ticks;
    int ntk;

    initial begin
        rst        = 1'b1;
        start      = 1'b1;
        delta_x    = '0;
        plat_x     = '0;
        plat_y     = '0;
        plat_valid = '0;
`ifdef JUMPER_SPRING_EN
        spring     = '0;
`endif
        beam_x     = '0;
        beam_y     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state",  state, 0);
        check("rst_pos_x",  pos_x, 472);
        check("rst_pos_y",  pos_y, 687);
        check("rst_vel",    vel_y, 0);
        check("rst_facing", facing_left, 0);
        check("rst_tick",   frame_tick, 0);
        check("rst_landed", landed, 0);
        check("rst_idx",    landed_idx, 0);
        check("rst_hit",    spr_hit, 0);
        check("rst_ax",     spr_ax, 0);
        check("rst_ay",     spr_ay, 0);

        rst   = 1'b0;
        start = 1'b0;
        ntk = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (frame_tick) ntk++;
        end
        check("tick_rate", ntk, 3);

        // IDLE holds position; facing follows delta_x.
        next_tick();
        check("idle_state", state, 0);
        delta_x = -9'sd3;
        next_tick();
        check("idle_pos_x", pos_x, 472);
        check("idle_pos_y", pos_y, 687);
        check("idle_face_l", facing_left, 1);
        delta_x = '0;

        // Sprite lookup with facing left at (472,687).
        beam_probe(475, 690);
        check("spr_hit_in", spr_hit, 1);
        check("spr_ax_mirror", spr_ax, 76);
        check("spr_ay", spr_ay, 3);
        beam_probe(552, 690);
        check("spr_hit_right", spr_hit, 0);
        check("spr_ax_miss", spr_ax, 0);
        check("spr_ay_miss", spr_ay, 0);
        beam_probe(551, 766);
        check("spr_hit_corner", spr_hit, 1);
        check("spr_ay_corner", spr_ay, 79);
        beam_probe(551, 767);
        check("spr_hit_below", spr_hit, 0);
        beam_probe(471, 690);
        check("spr_hit_left", spr_hit, 0);
        delta_x = 9'sd2;
        next_tick();
        check("idle_face_r", facing_left, 0);
        delta_x = '0;
        beam_probe(475, 690);
        check("spr_ax_right", spr_ax, 3);

        // Start the jump.
        start = 1'b1;
        next_tick();
        start = 1'b0;
        check("start_state", state, 1);
        check("start_vel", vel_y, -44);
        check("start_pos_y", pos_y, 687);

        // Rise to apex, exercising x wrap on the first ticks.
        for (int k = 1; k <= 11; k++) begin
            delta_x = (k <= 5) ? 9'(dtab[k]) : 9'sd0;
            next_tick();
            check("rise_y", pos_y, 687 - 44 * k + 2 * k * (k - 1));
            check("rise_vel", vel_y, -44 + 4 * k);
            check("rise_state", state, (k < 11) ? 1 : 2);
            if (k <= 5) begin
                check("wrap_x", pos_x, xtab[k]);
                check("face", facing_left, ftab[k]);
            end
        end
        delta_x = '0;
        next_tick();
        check("apex_y", pos_y, 423);
        check("apex_vel", vel_y, 4);
        next_tick();
        check("fall_y", pos_y, 427);
        check("fall_vel", vel_y, 8);

        // Landing: idx 1 and 3 both qualify, idx 0 misses by one pixel, idx 2 invalid.
        plat_x[0] = 11'd240; plat_y[0] = 10'd500;
        plat_x[1] = 11'd340; plat_y[1] = 10'd485;
        plat_x[2] = 11'd300; plat_y[2] = 10'd500;
        plat_x[3] = 11'd300; plat_y[3] = 10'd500;
        plat_valid = 4'b1011;
        next_tick();
        check("land_pulse", landed, 1);
        check("land_idx", landed_idx, 1);
        check("land_pos_y", pos_y, 405);
        check("land_vel", vel_y, -44);
        check("land_state", state, 1);
        plat_valid = '0;
        @(posedge clk);
        #1;
        check("land_pulse_end", landed, 0);

        // No platforms: rise again then fall out.
        ticks = 0;
        while (state != 2'd3 && ticks < 80) begin
            next_tick();
            ticks++;
        end
        check("dead_ticks", ticks, 29);
        check("dead_state", state, 3);
        check("dead_pos_y", pos_y, 688);
        check("dead_vel", vel_y, 72);
        delta_x = -9'sd5;
        next_tick();
        check("dead_hold_state", state, 3);
        check("dead_hold_x", pos_x, 300);
        check("dead_hold_y", pos_y, 688);
        check("dead_hold_face", facing_left, 0);
        delta_x = '0;
        start = 1'b1;
        next_tick();
        start = 1'b0;
        check("respawn_state", state, 0);
        check("respawn_x", pos_x, 472);
        check("respawn_y", pos_y, 687);
        check("respawn_vel", vel_y, 0);

        // Reset coincident with a tick mid-jump.
        start = 1'b1;
        next_tick();
        start = 1'b0;
        next_tick();
        check("mid_y", pos_y, 643);
        ntk = 0;
        while (frame_tick !== 1'b1 && ntk < 16) begin
            @(negedge clk);
            ntk++;
        end
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_state", state, 0);
        check("rst_mid_y", pos_y, 687);
        check("rst_mid_vel", vel_y, 0);
        check("rst_mid_landed", landed, 0);
        rst   = 1'b0;
        start = 1'b0;
        next_tick();
        check("post_rst_state", state, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
